// File: rtl/traffic_lights_pkg.sv
// Shared types and constants for the traffic light controller.
package traffic_lights_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_RED,
        ST_RED_YELLOW,
        ST_GREEN,
        ST_GREEN_BLINK,
        ST_YELLOW,
        ST_YELLOW_BLINK
    } state_t;

    localparam logic [2:0] CMD_ON           = 3'd0;
    localparam logic [2:0] CMD_OFF          = 3'd1;
    localparam logic [2:0] CMD_NOTRANSITION = 3'd2;
    localparam logic [2:0] CMD_SET_GREEN    = 3'd3;
    localparam logic [2:0] CMD_SET_RED      = 3'd4;
    localparam logic [2:0] CMD_SET_YELLOW   = 3'd5;

    localparam logic [15:0] DEF_GREEN_TIME  = 16'd16;
    localparam logic [15:0] DEF_RED_TIME    = 16'd16;
    localparam logic [15:0] DEF_YELLOW_TIME = 16'd6;

    function automatic logic [15:0] clamp_time(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/traffic_lights_ctrl.sv
// Command-driven three-lamp traffic signal controller.
// Lamps are registered from the next-state decode.
module traffic_lights_ctrl
    import traffic_lights_pkg::*;
#(
    parameter int unsigned BLINK_HALF_PERIOD = 2,
    parameter int unsigned BLINK_GREEN_TIME  = 8,
    parameter int unsigned RED_YELLOW_TIME   = 6
) (
    input  logic        clk_i,
    input  logic        srst_i,
    input  logic [2:0]  cmd_type_i,
    input  logic        cmd_valid_i,
    input  logic [15:0] cmd_data_i,
    output logic        red_o,
    output logic        yellow_o,
    output logic        green_o
);

    localparam logic [15:0] HALF       = 16'(BLINK_HALF_PERIOD);
    localparam logic [15:0] BLINK_LAST = 16'(2 * BLINK_HALF_PERIOD - 1);
    localparam logic [15:0] GB_TIME    = 16'(BLINK_GREEN_TIME);
    localparam logic [15:0] RY_TIME    = 16'(RED_YELLOW_TIME);

    state_t      state_q, state_d, auto_next;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] blink_q, blink_d;
    logic [15:0] dur_q, dur_d;
    logic [15:0] green_time_q, red_time_q, yellow_time_q;
    logic        entry, timed, blink_on;
    logic        red_d, yellow_d, green_d;

    always_comb begin
        state_d   = state_q;
        entry     = 1'b0;
        timed     = 1'b1;
        auto_next = state_q;
        case (state_q)
            ST_RED:         auto_next = ST_RED_YELLOW;
            ST_RED_YELLOW:  auto_next = ST_GREEN;
            ST_GREEN:       auto_next = ST_GREEN_BLINK;
            ST_GREEN_BLINK: auto_next = ST_YELLOW;
            ST_YELLOW:      auto_next = ST_RED;
            default:        timed     = 1'b0;
        endcase

        // State-changing commands win over a timer expiring this cycle.
        if (cmd_valid_i) begin
            case (cmd_type_i)
                CMD_ON: begin
                    if (state_q == ST_OFF || state_q == ST_YELLOW_BLINK) begin
                        state_d = ST_RED;
                        entry   = 1'b1;
                    end
                end
                CMD_OFF: begin
                    state_d = ST_OFF;
                    entry   = 1'b1;
                end
                CMD_NOTRANSITION: begin
                    state_d = ST_YELLOW_BLINK;
                    entry   = 1'b1;
                end
                default: ;
            endcase
        end

        if (!entry && timed && cnt_q == dur_q - 16'd1) begin
            state_d = auto_next;
            entry   = 1'b1;
        end

        // Duration is latched on entry so later SET_* leave it alone.
        dur_d = dur_q;
        if (entry) begin
            case (state_d)
                ST_RED:         dur_d = red_time_q;
                ST_RED_YELLOW:  dur_d = RY_TIME;
                ST_GREEN:       dur_d = green_time_q;
                ST_GREEN_BLINK: dur_d = GB_TIME;
                ST_YELLOW:      dur_d = yellow_time_q;
                default:        dur_d = 16'd1;
            endcase
        end

        cnt_d   = entry ? 16'd0 : cnt_q + 16'd1;
        blink_d = (entry || blink_q == BLINK_LAST) ? 16'd0 : blink_q + 16'd1;
        blink_on = blink_d < HALF;

        red_d    = 1'b0;
        yellow_d = 1'b0;
        green_d  = 1'b0;
        case (state_d)
            ST_RED:          red_d    = 1'b1;
            ST_RED_YELLOW: begin
                red_d    = 1'b1;
                yellow_d = 1'b1;
            end
            ST_GREEN:        green_d  = 1'b1;
            ST_GREEN_BLINK:  green_d  = blink_on;
            ST_YELLOW:       yellow_d = 1'b1;
            ST_YELLOW_BLINK: yellow_d = blink_on;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q       <= ST_OFF;
            cnt_q         <= 16'd0;
            blink_q       <= 16'd0;
            dur_q         <= 16'd1;
            green_time_q  <= DEF_GREEN_TIME;
            red_time_q    <= DEF_RED_TIME;
            yellow_time_q <= DEF_YELLOW_TIME;
            red_o         <= 1'b0;
            yellow_o      <= 1'b0;
            green_o       <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            blink_q  <= blink_d;
            dur_q    <= dur_d;
            red_o    <= red_d;
            yellow_o <= yellow_d;
            green_o  <= green_d;
            if (cmd_valid_i) begin
                case (cmd_type_i)
                    CMD_SET_GREEN:  green_time_q  <= clamp_time(cmd_data_i);
                    CMD_SET_RED:    red_time_q    <= clamp_time(cmd_data_i);
                    CMD_SET_YELLOW: yellow_time_q <= clamp_time(cmd_data_i);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_traffic_lights_ctrl.sv
// Segment-table bench for traffic_lights_ctrl with a lamp scoreboard.
module tb_traffic_lights_ctrl;

    localparam int H = 2;
    localparam int WATCHDOG = 20000;

    localparam logic [2:0] L_OFF = 3'b000;
    localparam logic [2:0] L_R   = 3'b100;
    localparam logic [2:0] L_RY  = 3'b110;
    localparam logic [2:0] L_G   = 3'b001;
    localparam logic [2:0] L_Y   = 3'b010;

    localparam int B_NONE = 0;
    localparam int B_GRN  = 1;
    localparam int B_YEL  = 2;

    typedef struct {
        logic        rst;
        logic        v;
        logic [2:0]  t;
        logic [15:0] d;
        int          n;
        logic [2:0]  lamps;
        int          blink;
        int          ph;
    } seg_t;

    typedef struct {
        logic [2:0] lamps;
        int         seg;
        int         idx;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        srst_i = 1'b0;
    logic [2:0]  cmd_type_i = 3'd0;
    logic        cmd_valid_i = 1'b0;
    logic [15:0] cmd_data_i = 16'd0;
    logic        red_o, yellow_o, green_o;
    logic        done = 1'b0;

    seg_t segs[$];
    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    traffic_lights_ctrl dut (
        .clk_i       (clk_i),
        .srst_i      (srst_i),
        .cmd_type_i  (cmd_type_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_data_i  (cmd_data_i),
        .red_o       (red_o),
        .yellow_o    (yellow_o),
        .green_o     (green_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        repeat (WATCHDOG) @(posedge clk_i);
        if (!done) begin
            $display("FAIL timeout: sequence not finished after %0d cycles", WATCHDOG);
            $finish;
        end
    end

    task automatic add(input logic rst, input logic v, input logic [2:0] t,
                       input logic [15:0] d, input int n,
                       input logic [2:0] lamps, input int blink, input int ph);
        seg_t s;
        s.rst = rst; s.v = v; s.t = t; s.d = d; s.n = n;
        s.lamps = lamps; s.blink = blink; s.ph = ph;
        segs.push_back(s);
    endtask

    function automatic logic [2:0] expect_lamps(seg_t s, int k);
        logic on;
        on = ((k + s.ph) % (2 * H)) < H;
        case (s.blink)
            B_GRN:   return {2'b00, on};
            B_YEL:   return {1'b0, on, 1'b0};
            default: return s.lamps;
        endcase
    endfunction

    initial begin
        exp_t e;
        logic [2:0] act;

        add(1, 0, 0, 0, 1, L_OFF, B_NONE, 0);
        add(0, 1, 0, 0, 16, L_R, B_NONE, 0);
        add(0, 0, 0, 0, 6, L_RY, B_NONE, 0);
        add(0, 0, 0, 0, 16, L_G, B_NONE, 0);
        add(0, 0, 0, 0, 8, L_OFF, B_GRN, 0);
        add(0, 0, 0, 0, 6, L_Y, B_NONE, 0);
        add(0, 0, 0, 0, 5, L_R, B_NONE, 0);
        add(0, 1, 3, 3, 11, L_R, B_NONE, 0);
        add(0, 0, 0, 0, 6, L_RY, B_NONE, 0);
        add(0, 0, 0, 0, 3, L_G, B_NONE, 0);
        add(0, 0, 0, 0, 8, L_OFF, B_GRN, 0);
        add(0, 0, 0, 0, 5, L_Y, B_NONE, 0);
        add(0, 1, 4, 0, 1, L_Y, B_NONE, 0);
        add(0, 0, 0, 0, 1, L_R, B_NONE, 0);
        add(0, 0, 0, 0, 6, L_RY, B_NONE, 0);
        add(0, 0, 0, 0, 2, L_G, B_NONE, 0);
        add(0, 1, 0, 0, 1, L_G, B_NONE, 0);
        add(0, 1, 6, 5, 4, L_OFF, B_GRN, 0);
        add(0, 1, 7, 9, 4, L_OFF, B_GRN, 0);
        add(0, 0, 0, 0, 6, L_Y, B_NONE, 0);
        add(0, 0, 0, 0, 1, L_R, B_NONE, 0);
        add(0, 0, 0, 0, 6, L_RY, B_NONE, 0);
        add(0, 0, 0, 0, 2, L_G, B_NONE, 0);
        add(0, 1, 2, 0, 42, L_OFF, B_YEL, 0);
        add(0, 1, 2, 0, 6, L_OFF, B_YEL, 0);
        add(0, 1, 0, 0, 1, L_R, B_NONE, 0);
        add(0, 0, 0, 0, 3, L_RY, B_NONE, 0);
        add(0, 1, 1, 0, 2, L_OFF, B_NONE, 0);
        add(0, 1, 4, 10, 2, L_OFF, B_NONE, 0);
        add(0, 1, 0, 0, 10, L_R, B_NONE, 0);
        add(0, 0, 0, 0, 2, L_RY, B_NONE, 0);
        add(0, 1, 2, 0, 8, L_OFF, B_YEL, 0);
        add(1, 1, 0, 0, 1, L_OFF, B_NONE, 0);
        add(0, 1, 0, 0, 16, L_R, B_NONE, 0);
        add(0, 0, 0, 0, 6, L_RY, B_NONE, 0);
        add(0, 0, 0, 0, 16, L_G, B_NONE, 0);
        add(0, 1, 5, 2, 8, L_OFF, B_GRN, 0);
        add(0, 0, 0, 0, 2, L_Y, B_NONE, 0);
        add(0, 0, 0, 0, 3, L_R, B_NONE, 0);

        for (int s = 0; s < segs.size(); s++) begin
            for (int k = 0; k < segs[s].n; k++) begin
                srst_i      = (k == 0) && segs[s].rst;
                cmd_valid_i = (k == 0) && segs[s].v;
                cmd_type_i  = segs[s].t;
                cmd_data_i  = segs[s].d;
                e.lamps = expect_lamps(segs[s], k);
                e.seg   = s;
                e.idx   = k;
                sb.push_back(e);
                @(posedge clk_i);
                #1;
                e   = sb.pop_front();
                act = {red_o, yellow_o, green_o};
                vectors++;
                if (act !== e.lamps) begin
                    miscompares++;
                    $display("FAIL seg%0d cyc%0d lamps(ryg) got %b expected %b",
                             e.seg, e.idx, act, e.lamps);
                end
                if (k == 0 && segs[s].rst && act !== 3'b000) begin
                    miscompares++;
                    $display("FAIL reset seg%0d lamps(ryg) got %b expected 000",
                             s, act);
                end
            end
        end

        done = 1'b1;
        if (miscompares != 0)
            $display("FAIL == %0d vectors applied, %0d miscompares ==",
                     vectors, miscompares);
        else
            $display("PASS == %0d vectors applied, 0 miscompares ==", vectors);
        $finish;
    end

endmodule
